uart_rx_frame: RTL and testbench

- Downstream stage of the UART start-bit detector.
- Takes the detector's start flag plus the raw serial line and validates the start bit at mid-bit.
- Deserialises DATA_BITS LSB-first at mid-bit points of an oversampled baud tick, checks the stop bit, and presents a parallel byte with a one-cycle valid strobe.
- Drives the arm signal back to the detector.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx_frame.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive framer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Expected parity bit for a zero-extended payload of up to 9 bits.
  function automatic logic par_calc(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {2{RST_VAL}};
    else       sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: validates start, deserialises LSB-first, checks stop.
// Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic                 strt_bit,
  output logic                 start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s, st_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (.clk(clk), .reset(reset), .d(rx_in),    .q(rx_s));
  uart_sync2 #(.RST_VAL(1'b0)) u_sync_st (.clk(clk), .reset(reset), .d(strt_bit), .q(st_s));

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pm_q, pm_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    pm_d    = pm_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A flag still high from the previous frame is ignored while the line idles.
        if (st_s && !rx_s) begin
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              tick_d  = '0;
              bit_d   = '0;
              pm_d    = 1'b0;
              state_d = ST_DATA;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            sh_d   = {rx_s, sh_q[DATA_BITS-1:1]};
            bit_d  = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            pm_d    = (rx_s != par_calc(9'(sh_q), PARITY_ODD[0]));
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            if (!rx_s) begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end else if (pm_q) begin
              perr_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              data_d  = sh_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      pm_q    <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      pm_q    <= pm_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

`ifndef UART_RX_PARITY_EN
  logic unused_par;
  assign unused_par = PARITY_ODD[0];
`endif

  assign start      = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: frames, back-to-back, glitch, break, reset.
module tb_uart_rx_frame;

  localparam int DB        = 8;
  localparam int OS        = 16;
  localparam int TICK_CLKS = 4;
  localparam int BIT_CLKS  = OS * TICK_CLKS;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          baud_tick;
  logic          rx_in;
  logic          strt_bit;
  logic          start;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  exp_t       sb_q[$];
  int         checks = 0;
  int         passes = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_strb = 1'b0;
  int         nstrb;
  logic [1:0] got_kind;
  exp_t       exp_e;

  uart_rx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_in), .strt_bit(strt_bit),
    .start(start), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TICK_CLKS - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  // Scoreboard monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    nstrb = int'(rx_valid) + int'(frame_err) + int'(parity_err);
    if (nstrb != 0) begin
      checks++;
      if (nstrb != 1 || prev_strb)
        $display("FAIL strobe_shape: count=%0d prev=%0b required single 1-clk strobe", nstrb, prev_strb);
      else passes++;
      got_kind = rx_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_strobe: kind=%0d data=%h required none", got_kind, rx_data);
      end else begin
        exp_e = sb_q.pop_front();
        if (got_kind !== exp_e.kind)
          $display("FAIL strobe_kind: got %0d required %0d", got_kind, exp_e.kind);
        else passes++;
        checks++;
        if (rx_data !== exp_e.data)
          $display("FAIL strobe_data: got %h required %h", rx_data, exp_e.data);
        else passes++;
      end
    end
    prev_strb = (nstrb != 0);
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    exp_t e;
    e.kind = K_VALID;
    e.data = d;
    sb_q.push_back(e);
    last_good = d;
    strt_bit  = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(1'b1);
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0)
      $display("FAIL %s_pending: %0d expected strobes missing, required 0", name, sb_q.size());
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_in = 1'b1; strt_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (start !== 1'b1) $display("FAIL rst_start: got %b required 1", start); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else passes++;
    checks++; if (rx_data !== 8'h00) $display("FAIL rst_data: got %h required 00", rx_data); else passes++;
    checks++;
    if ({rx_valid, frame_err, parity_err} !== 3'b000)
      $display("FAIL rst_strobes: got %b required 000", {rx_valid, frame_err, parity_err});
    else passes++;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    send_frame(8'hFF);
    send_frame(8'h00);
    // Line idles high while strt_bit stays asserted.
    repeat (3) drive_bit(1'b1);
    check_sb_empty("b2b");
    checks++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b required 0", busy); else passes++;
    checks++; if (rx_data !== 8'h00) $display("FAIL b2b_data: got %h required 00", rx_data); else passes++;
  endtask

  task automatic test_basic;
    strt_bit = 1'b0;
    drive_bit(1'b1);
    send_frame(8'h55);
    repeat (4) @(posedge clk);
    #1;
    check_sb_empty("basic");
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b required 0", busy); else passes++;
    checks++; if (start !== 1'b1) $display("FAIL basic_start: got %b required 1", start); else passes++;
    checks++; if (rx_data !== 8'h55) $display("FAIL basic_data: got %h required 55", rx_data); else passes++;
  endtask

  task automatic test_glitch;
    strt_bit = 1'b0;
    drive_bit(1'b1);
    rx_in = 1'b0; strt_bit = 1'b1;
    repeat (2 * TICK_CLKS) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL glitch_armed: got busy %b required 1", busy); else passes++;
    repeat (2 * TICK_CLKS) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (6 * TICK_CLKS) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL glitch_idle: got busy %b required 0", busy); else passes++;
    drive_bit(1'b1);
    check_sb_empty("glitch");
  endtask

  task automatic test_frame_err;
    exp_t e;
    logic [7:0] d;
    d = 8'hA3;
    e.kind = K_FERR;
    e.data = last_good;
    sb_q.push_back(e);
    strt_bit = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    rx_in = 1'b0;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    check_sb_empty("ferr");
    checks++; if (busy !== 1'b1) $display("FAIL ferr_break_busy: got %b required 1", busy); else passes++;
    rx_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL ferr_release: got busy %b required 0", busy); else passes++;
    checks++;
    if (rx_data !== last_good) $display("FAIL ferr_data_kept: got %h required %h", rx_data, last_good);
    else passes++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'h3C;
    strt_bit = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_in = d[4];
    repeat (BIT_CLKS / 2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) $display("FAIL midrst_data: got %h required 00", rx_data); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy); else passes++;
    checks++; if (start !== 1'b1) $display("FAIL midrst_start: got %b required 1", start); else passes++;
    last_good = 8'h00;
    sb_q.delete();
    rx_in = 1'b1; strt_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drive_bit(1'b1);
    send_frame(d);
    repeat (4) @(posedge clk);
    #1;
    check_sb_empty("midrst");
    checks++; if (rx_data !== 8'h3C) $display("FAIL midrst_reframe: got %h required 3C", rx_data); else passes++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    exp_t e;
    logic [7:0] d;
    d = 8'h07;
    for (int pass = 0; pass < 2; pass++) begin
      e.kind = (pass == 0) ? K_VALID : K_PERR;
      e.data = (pass == 0) ? d : last_good;
      sb_q.push_back(e);
      if (pass == 0) last_good = d;
      strt_bit = 1'b1;
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i]);
      drive_bit((pass == 0) ? 1'b1 : 1'b0);
      drive_bit(1'b1);
      check_sb_empty("parity");
      checks++;
      if (rx_data !== 8'h07) $display("FAIL parity_data: got %h required 07", rx_data);
      else passes++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_basic;
    test_glitch;
    test_frame_err;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
